// File: rtl/pulse_req_queue.sv
// rtl/pulse_req_queue.sv - counts event requests and issues them one at a time over a level ack handshake
//
// Ports:
//   clk_s        source-domain clock, all state on its rising edge
//   rstn_s       asynchronous active-low reset
//   req_in       one request per cycle it is high
//   ack_in       downstream ready level (high = can accept an event)
//   clr_err      clears the sticky overflow / timeout_err flags
//   event_out    registered single-cycle event pulse (high only in ISSUE)
//   pending      queued, not yet issued requests (saturating)
//   busy         registered, high while the FSM is not in IDLE
//   overflow     sticky: a request was dropped at full count
//   timeout_err  sticky: an ack phase exceeded TIMEOUT cycles
module pulse_req_queue #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_s,
  input  logic             rstn_s,
  input  logic             req_in,
  input  logic             ack_in,
  input  logic             clr_err,
  output logic             event_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [TMR_W-1:0] timer;
  logic             iss;
  logic             acc;
  logic             drop;
  logic             tmo;

  // Next-state logic. A normal exit is tested before the timeout so that
  // an ack edge arriving on the last allowed cycle still counts as success.
  always_comb begin
    state_next = IDLE;
    iss        = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: begin
        state_next = IDLE;
        if (pending != '0 && ack_in) begin
          state_next = ISSUE;
          iss        = 1'b1;
        end
      end
      ISSUE: state_next = WAIT_LOW;
      WAIT_LOW: begin
        state_next = WAIT_LOW;
        if (!ack_in) begin
          state_next = WAIT_HIGH;
        end else if (timer == TMR_LIMIT) begin
          state_next = IDLE;
          tmo        = 1'b1;
        end
      end
      WAIT_HIGH: begin
        state_next = WAIT_HIGH;
        if (ack_in) begin
          state_next = IDLE;
        end else if (timer == TMR_LIMIT) begin
          state_next = IDLE;
          tmo        = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // At full count a request is only accepted when an issue frees a slot
  // in the same cycle; otherwise it is dropped and flagged.
  always_comb begin
    acc  = req_in && ((pending != PEND_MAX) || iss);
    drop = req_in && !acc;
  end

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      state       <= IDLE;
      pending     <= '0;
      timer       <= '0;
      event_out   <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;

      if (acc && !iss) begin
        pending <= pending + CNT_W'(1);
      end else if (iss && !acc) begin
        pending <= pending - CNT_W'(1);
      end

      // WAIT_LOW is only ever entered from ISSUE, so clearing in ISSUE is
      // clearing on entry. The timer is held across WAIT_LOW->WAIT_HIGH.
      if (state == ISSUE) begin
        timer <= '0;
      end else if ((state == WAIT_LOW || state == WAIT_HIGH) && timer != TMR_LIMIT) begin
        timer <= timer + TMR_W'(1);
      end

      // Outputs registered from the next state so they align with state.
      event_out <= (state_next == ISSUE);
      busy      <= (state_next != IDLE);

      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end

      if (tmo) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule
